// File: rtl/mem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_ctrl_if : request/response and byte-RAM bus for mem_ctrl        |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
interface mem_ctrl_if;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        jump_or_not;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_wr;
  logic        busy;

  modport slave (
    input  rdy, if_req, if_addr, mem_req, mem_we, mem_addr, mem_len,
           mem_wdata, jump_or_not, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_a, ram_dout,
           ram_wr, busy
  );

  modport master (
    output rdy, if_req, if_addr, mem_req, mem_we, mem_addr, mem_len,
           mem_wdata, jump_or_not, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_a, ram_dout,
           ram_wr, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_ctrl : byte-serial fetch/load/store controller for an 8-bit RAM |
// | Option   : MEMCTRL_FETCH_ABORT_EN lets jump_or_not abort a FETCH    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [31:0] base_q, wdata_q, buf_q, buf_nx;
  logic [31:0] if_data_q, mem_rdata_q, ram_a_q, next_a;
  logic [7:0]  ram_dout_q;
  logic        ram_wr_q, fetch_q;
  logic [2:0]  cnt_q, nbytes_q;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_sh, st_sh;
  logic        abort;
  logic        busy_c, if_done_c, mem_done_c;

`ifdef MEMCTRL_FETCH_ABORT_EN
  assign abort = bus.jump_or_not;
`else
  assign abort = 1'b0 & bus.jump_or_not;
`endif

  // cnt_q holds the index of the upcoming edge counted from acceptance
  assign next_a  = base_q + {29'd0, cnt_q};
  assign cap_idx = cnt_q[1:0] - 2'd2;
  assign cap_sh  = {cap_idx, 3'b000};
  assign st_sh   = {cnt_q[1:0], 3'b000};

  always_comb begin
    buf_nx = buf_q;
    if (cnt_q >= 3'd2) buf_nx[cap_sh +: 8] = bus.ram_din;
  end

  always_comb begin
    state_nx   = state;
    busy_c     = (state != S_IDLE);
    if_done_c  = 1'b0;
    mem_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_req)     state_nx = bus.mem_we ? S_STORE : S_LOAD;
        else if (bus.if_req) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (abort)                             state_nx = S_IDLE;
        else if (cnt_q == nbytes_q + 3'd1)     state_nx = S_DONE;
      end
      S_LOAD:  if (cnt_q == nbytes_q + 3'd1)   state_nx = S_DONE;
      S_STORE: if (cnt_q == nbytes_q)          state_nx = S_DONE;
      S_DONE: begin
        state_nx   = S_IDLE;
        if_done_c  = fetch_q;
        mem_done_c = ~fetch_q;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      fetch_q     <= 1'b0;
      cnt_q       <= '0;
      nbytes_q    <= '0;
    end else if (bus.rdy) begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (state_nx != S_IDLE) begin
            cnt_q    <= 3'd1;
            buf_q    <= '0;
            wdata_q  <= bus.mem_wdata;
            fetch_q  <= (state_nx == S_FETCH);
            ram_wr_q <= (state_nx == S_STORE);
            if (state_nx == S_FETCH) begin
              base_q   <= bus.if_addr;
              ram_a_q  <= bus.if_addr;
              nbytes_q <= 3'd4;
            end else begin
              base_q   <= bus.mem_addr;
              ram_a_q  <= bus.mem_addr;
              nbytes_q <= {1'b0, bus.mem_len} + 3'd1;
            end
            if (state_nx == S_STORE) ram_dout_q <= bus.mem_wdata[7:0];
          end
        end
        S_FETCH, S_LOAD: begin
          cnt_q <= cnt_q + 3'd1;
          buf_q <= buf_nx;
          if (cnt_q < nbytes_q) ram_a_q <= next_a;
          if (state_nx == S_DONE) begin
            if (fetch_q) if_data_q   <= buf_nx;
            else         mem_rdata_q <= buf_nx;
          end
        end
        S_STORE: begin
          cnt_q <= cnt_q + 3'd1;
          if (state_nx == S_DONE) begin
            ram_wr_q <= 1'b0;
          end else begin
            ram_a_q    <= next_a;
            ram_dout_q <= wdata_q[st_sh +: 8];
          end
        end
        default: ram_wr_q <= 1'b0;
      endcase
    end
  end

  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  // a stalled store must not repeat its byte while rdy is low
  assign bus.ram_wr    = ram_wr_q & bus.rdy;
  assign bus.busy      = busy_c;
  assign bus.if_done   = if_done_c;
  assign bus.mem_done  = mem_done_c;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_ctrl : directed self-checking bench with byte-level model    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // environment RAM (written by the DUT) and reference memory (written by the model)
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  int          exp_kind [$];   // 0 fetch, 1 load, 2 store
  logic [31:0] exp_data [$];
  logic [39:0] exp_wr   [$];   // {addr, byte}

  logic [31:0] a_seen [8];
  int          wr_cnt;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]    = b;
    shadow[a] = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_bad(input string name);
    n_checks++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_a);
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  end

  // compare process: every RAM write and every done pulse against the model queues
  always @(posedge clk) begin
    logic [39:0] e;
    logic [31:0] ed;
    #1;
    if (!rst) begin
      if (bus.ram_wr) begin
        if (exp_wr.size() == 0) chk_bad("unexpected_ram_wr");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.ram_a, e[39:8]);
          chk("wr_byte", {24'd0, bus.ram_dout}, {24'd0, e[7:0]});
        end
      end
      if (bus.if_done) begin
        if (exp_kind.size() == 0 || exp_kind[0] != 0) chk_bad("unexpected_if_done");
        else begin
          void'(exp_kind.pop_front());
          ed = exp_data.pop_front();
          chk("if_data", bus.if_data, ed);
        end
      end
      if (bus.mem_done) begin
        if (exp_kind.size() == 0 || exp_kind[0] == 0) chk_bad("unexpected_mem_done");
        else begin
          ed = exp_data.pop_front();
          if (exp_kind.pop_front() == 1) chk("mem_rdata", bus.mem_rdata, ed);
        end
      end
    end
  end

  task automatic expect_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                            input logic [31:0] wd);
    int n;
    logic [31:0] d;
    n = (kind == 0) ? 4 : int'(len) + 1;
    d = '0;
    for (int i = 0; i < n; i++) begin
      if (kind == 2) begin
        exp_wr.push_back({addr + i, wd[8*i +: 8]});
        shadow[addr + i] = wd[8*i +: 8];
      end else begin
        d[8*i +: 8] = sh_rd(addr + i);
      end
    end
    exp_kind.push_back(kind);
    exp_data.push_back(d);
  endtask

  task automatic wait_done(input bit fetch, output int edges);
    bit done;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
      done = fetch ? bus.if_done : bus.mem_done;
    end
  endtask

  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd, input int stall_after, input bit jmp,
                         input string name);
    int n, exp_edges, edges;
    bit done;
    n = (kind == 0) ? 4 : int'(len) + 1;
    exp_edges = ((kind == 2) ? n + 1 : n + 2) + ((stall_after > 0) ? 3 : 0);
    expect_txn(kind, addr, len, wd);
    bus.jump_or_not = jmp;
    if (kind == 0) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = (kind == 2); bus.mem_addr = addr;
      bus.mem_len = len;  bus.mem_wdata = wd;
    end
    edges = 0; done = 1'b0; wr_cnt = 0;
    while (!done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (edges <= 8) a_seen[edges-1] = bus.ram_a;
      if (bus.ram_wr) wr_cnt++;
      done = (kind == 0) ? bus.if_done : bus.mem_done;
      if (edges == 1) begin
        bus.if_addr = ~addr; bus.mem_addr = ~addr; bus.mem_wdata = ~wd;
        bus.mem_len = ~len;  bus.mem_we = ~bus.mem_we;
      end
      if (!done && edges == stall_after) begin
        bus.rdy = 1'b0;
        repeat (3) begin
          @(posedge clk); edges++;
          @(negedge clk);
          chk({name, "_stall_ram_wr"}, bus.ram_wr, 0);
          chk({name, "_stall_busy"}, bus.busy, 1);
        end
        bus.rdy = 1'b1;
      end
    end
    chk({name, "_latency"}, edges, exp_edges);
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.jump_or_not = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int e1, e2;
    bus.rdy = 1'b1; bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_len = '0; bus.mem_wdata = '0;
    bus.jump_or_not = 1'b0;

    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h50); poke(32'h103, 8'h00);
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    poke(32'h3FD, 8'h11);
    poke(32'hFFFFFFFE, 8'h01); poke(32'hFFFFFFFF, 8'h02);
    poke(32'h00000000, 8'h03); poke(32'h00000001, 8'h04);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_data", bus.if_data, 0);   chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_ram_a", bus.ram_a, 0);       chk("rst_ram_dout", bus.ram_dout, 0);
    chk("rst_ram_wr", bus.ram_wr, 0);     chk("rst_busy", bus.busy, 0);
    chk("rst_if_done", bus.if_done, 0);   chk("rst_mem_done", bus.mem_done, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    run_txn(0, 32'h100, 2'd0, 32'h0, 0, 1'b0, "fetch_word");
    chk("fetch_word_lit", bus.if_data, 32'h00500013);

    run_txn(2, 32'h3FE, 2'd1, 32'hAABBCCDD, 0, 1'b0, "store_half");
    chk("store_half_wrcnt", wr_cnt, 2);
    chk("store_half_ram3FE", {24'd0, ram_rd(32'h3FE)}, 32'hDD);
    chk("store_half_ram3FF", {24'd0, ram_rd(32'h3FF)}, 32'hCC);

    run_txn(1, 32'h3FD, 2'd2, 32'h0, 0, 1'b0, "load3");
    chk("load3_lit", bus.mem_rdata, 32'h00CCDD11);
    chk("if_data_hold", bus.if_data, 32'h00500013);

    run_txn(0, 32'hFFFFFFFE, 2'd0, 32'h0, 0, 1'b0, "fetch_wrap");
    chk("wrap_a0", a_seen[0], 32'hFFFFFFFE); chk("wrap_a1", a_seen[1], 32'hFFFFFFFF);
    chk("wrap_a2", a_seen[2], 32'h00000000); chk("wrap_a3", a_seen[3], 32'h00000001);
    chk("fetch_wrap_lit", bus.if_data, 32'h04030201);

    run_txn(1, 32'h201, 2'd0, 32'h0, 0, 1'b1, "load_byte_jump");
    chk("load_byte_lit", bus.mem_rdata, 32'h000000BE);

    // simultaneous requests: load first, fetch in the IDLE cycle after mem_done
    expect_txn(1, 32'h200, 2'd3, 32'h0);
    expect_txn(0, 32'h100, 2'd0, 32'h0);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h200; bus.mem_len = 2'd3;
    bus.if_req = 1'b1;  bus.if_addr = 32'h100;
    wait_done(1'b0, e1);
    chk("both_load_latency", e1, 6);
    chk("both_load_lit", bus.mem_rdata, 32'hDEADBEEF);
    bus.mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("both_idle_gap_busy", bus.busy, 0);
    wait_done(1'b1, e2);
    chk("both_fetch_latency", e2 + 1, 7);
    bus.if_req = 1'b0;
    @(posedge clk); @(negedge clk);

    run_txn(2, 32'h300, 2'd3, 32'h12345678, 2, 1'b0, "store_stall");
    chk("store_stall_wrcnt", wr_cnt, 4);
    run_txn(1, 32'h300, 2'd3, 32'h0, 0, 1'b0, "load_back");
    chk("load_back_lit", bus.mem_rdata, 32'h12345678);

    // jump_or_not in the third FETCH cycle
`ifndef MEMCTRL_FETCH_ABORT_EN
    expect_txn(0, 32'h100, 2'd0, 32'h0);
`endif
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    bus.jump_or_not = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.jump_or_not = 1'b0;
`ifdef MEMCTRL_FETCH_ABORT_EN
    chk("abort_busy", bus.busy, 0);
    chk("abort_if_done", bus.if_done, 0);
    bus.if_req = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    chk("abort_still_idle", bus.busy, 0);
`else
    chk("noabort_busy", bus.busy, 1);
    wait_done(1'b1, e1);
    chk("noabort_latency", e1 + 4, 6);
    bus.if_req = 1'b0;
    @(posedge clk); @(negedge clk);
`endif

    // reset in the middle of a load
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h200; bus.mem_len = 2'd3;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("preload_busy", bus.busy, 1);
    rst = 1'b1; bus.mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_if_data", bus.if_data, 0);   chk("mid_rst_mem_rdata", bus.mem_rdata, 0);
    chk("mid_rst_ram_a", bus.ram_a, 0);       chk("mid_rst_ram_dout", bus.ram_dout, 0);
    chk("mid_rst_ram_wr", bus.ram_wr, 0);     chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dones", {bus.if_done, bus.mem_done}, 0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("post_rst_idle", bus.busy, 0);
    chk("queues_drained", exp_kind.size() + exp_wr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
